// File: rtl/pixel_pkg.sv
// Shared types and constants for the pixel word unpacker.
//   rgb24_t        : packed {r,g,b} pixel payload
//   unpack_state_t : unpacker control states
package pixel_pkg;

    localparam int unsigned DEF_WORD_W   = 256;
    localparam int unsigned DEF_SLOT_W   = 32;
    localparam int unsigned PIX_W        = 24;
    localparam int unsigned PIX_PER_WORD = DEF_WORD_W / DEF_SLOT_W;
    localparam int unsigned SLOT_IDX_W   = 3;

    typedef struct packed {
        logic [7:0] r;
        logic [7:0] g;
        logic [7:0] b;
    } rgb24_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        FILL = 2'd1,
        RUN  = 2'd2
    } unpack_state_t;

endpackage

// File: rtl/word_prefetch_buf.sv
// Two-entry word buffer (cur + prefetch nxt) in front of a fixed-latency FIFO read port.
// Ports:
//   i_clk, i_rst_n : clock, synchronous active-low reset
//   i_en           : requests allowed (unpacker out of IDLE)
//   i_pop          : last pixel of cur accepted this cycle
//   i_word         : FIFO read data, valid RD_LATENCY clocks after o_req
//   o_req          : FIFO read request (one word per high cycle)
//   o_cur          : word currently being unpacked
//   o_cur_valid    : o_cur holds a word
module word_prefetch_buf #(
    parameter int unsigned WORD_W     = 256,
    parameter int unsigned RD_LATENCY = 1
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_en,
    input  logic              i_pop,
    input  logic [WORD_W-1:0] i_word,
    output logic              o_req,
    output logic [WORD_W-1:0] o_cur,
    output logic              o_cur_valid
);

    logic [WORD_W-1:0]     r_cur;
    logic [WORD_W-1:0]     r_nxt;
    logic                  r_cur_valid;
    logic                  r_nxt_valid;
    logic [RD_LATENCY-1:0] r_pipe;

    logic w_arrive;
    logic w_busy;
    logic w_req;

    // The arriving slot still counts as in flight, keeping one request outstanding at most.
    assign w_arrive = r_pipe[RD_LATENCY-1];
    assign w_busy   = |r_pipe;
    assign w_req    = i_en && !r_nxt_valid && !w_busy && !(!r_cur_valid && w_arrive);

    // Request tracker and buffer update; an arriving word bypasses nxt when cur empties this cycle.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_pipe      <= '0;
            r_cur       <= '0;
            r_nxt       <= '0;
            r_cur_valid <= 1'b0;
            r_nxt_valid <= 1'b0;
        end else begin
            r_pipe <= (r_pipe << 1) | RD_LATENCY'(w_req);
            if (i_pop) begin
                if (r_nxt_valid) begin
                    r_cur       <= r_nxt;
                    r_cur_valid <= 1'b1;
                    r_nxt_valid <= 1'b0;
                end else if (w_arrive) begin
                    r_cur       <= i_word;
                    r_cur_valid <= 1'b1;
                end else begin
                    r_cur_valid <= 1'b0;
                end
            end else if (w_arrive) begin
                if (!r_cur_valid) begin
                    r_cur       <= i_word;
                    r_cur_valid <= 1'b1;
                end else begin
                    r_nxt       <= i_word;
                    r_nxt_valid <= 1'b1;
                end
            end
        end
    end

    assign o_req       = w_req;
    assign o_cur       = r_cur;
    assign o_cur_valid = r_cur_valid;

endmodule

// File: rtl/pixel_word_unpacker.sv
// Unpacks 256-bit FIFO words into 24-bit RGB pixels over valid/ready, tagging line/frame markers.
// Ports:
//   clk_i, rst_n_i  : pixel clock, synchronous active-low reset
//   start_i         : frame data present in FIFO
//   word_i / req_o  : FIFO read data / read request
//   pix_data_o      : {R,G,B} of current pixel, zero when not valid
//   pix_valid_o     : pixel and markers valid; pix_ready_i accepts
//   sol_o/eol_o/sof_o : start of line / end of line / start of frame
//   underflow_o     : sticky, consumer was ready in RUN with no pixel available
module pixel_word_unpacker
    import pixel_pkg::*;
#(
    parameter int unsigned WORD_W     = DEF_WORD_W,
    parameter int unsigned SLOT_W     = DEF_SLOT_W,
    parameter int unsigned RD_LATENCY = 1,
    parameter int unsigned H_ACTIVE   = 1920,
    parameter int unsigned V_ACTIVE   = 1080
) (
    input  logic              clk_i,
    input  logic              rst_n_i,
    input  logic              start_i,
    input  logic [WORD_W-1:0] word_i,
    output logic              req_o,
    output logic [23:0]       pix_data_o,
    output logic              pix_valid_o,
    input  logic              pix_ready_i,
    output logic              sol_o,
    output logic              eol_o,
    output logic              sof_o,
    output logic              underflow_o
);

    localparam int unsigned H_W = (H_ACTIVE > 1) ? $clog2(H_ACTIVE) : 1;
    localparam int unsigned V_W = (V_ACTIVE > 1) ? $clog2(V_ACTIVE) : 1;

    unpack_state_t         r_state;
    logic [SLOT_IDX_W-1:0] r_slot;
    logic [H_W-1:0]        r_h;
    logic [V_W-1:0]        r_v;
    logic                  r_underflow;

    logic [WORD_W-1:0] w_cur;
    logic              w_cur_valid;
    logic              w_en;
    logic              w_fire;
    logic              w_word_done;
    logic              w_h_last;
    logic              w_v_last;
    rgb24_t            w_pix;

    assign w_en        = (r_state != IDLE);
    assign w_fire      = w_cur_valid && pix_ready_i;
    assign w_word_done = w_fire && (r_slot == SLOT_IDX_W'(PIX_PER_WORD - 1));
    assign w_h_last    = (r_h == H_W'(H_ACTIVE - 1));
    assign w_v_last    = (r_v == V_W'(V_ACTIVE - 1));

    word_prefetch_buf #(
        .WORD_W     (WORD_W),
        .RD_LATENCY (RD_LATENCY)
    ) u_buf (
        .i_clk       (clk_i),
        .i_rst_n     (rst_n_i),
        .i_en        (w_en),
        .i_pop       (w_word_done),
        .i_word      (word_i),
        .o_req       (req_o),
        .o_cur       (w_cur),
        .o_cur_valid (w_cur_valid)
    );

    // Control FSM: RUN is left only through reset, frames follow back to back.
    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            r_state <= IDLE;
        end else begin
            case (r_state)
                IDLE:    if (start_i)     r_state <= FILL;
                FILL:    if (w_cur_valid) r_state <= RUN;
                RUN:                      r_state <= RUN;
                default:                  r_state <= IDLE;
            endcase
        end
    end

    // Slot and raster position advance only on an accepted pixel.
    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            r_slot      <= '0;
            r_h         <= '0;
            r_v         <= '0;
            r_underflow <= 1'b0;
        end else begin
            if (w_fire) begin
                r_slot <= r_slot + SLOT_IDX_W'(1);
                if (w_h_last) begin
                    r_h <= '0;
                    r_v <= w_v_last ? '0 : r_v + V_W'(1);
                end else begin
                    r_h <= r_h + H_W'(1);
                end
            end
            if ((r_state == RUN) && pix_ready_i && !w_cur_valid) begin
                r_underflow <= 1'b1;
            end
        end
    end

    // Slot mux: slot 0 sits in the low bits, the top byte of each slot is padding.
    always_comb begin
        w_pix = '0;
        if (w_cur_valid) begin
            w_pix = rgb24_t'(w_cur[32'(r_slot) * SLOT_W +: PIX_W]);
        end
    end

    assign pix_valid_o = w_cur_valid;
    assign pix_data_o  = w_pix;
    assign sol_o       = w_cur_valid && (r_h == '0);
    assign eol_o       = w_cur_valid && w_h_last;
    assign sof_o       = w_cur_valid && (r_h == '0) && (r_v == '0);
    assign underflow_o = r_underflow;

endmodule

// File: tb/tb_pixel_word_unpacker.sv
// Bench for pixel_word_unpacker: channel 0 uses a 6-clock FIFO, channel 1 a slow 12-clock FIFO.
module tb_pixel_word_unpacker;

    localparam int unsigned HA = 16;
    localparam int unsigned VA = 2;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [1:0]  start;
    logic [1:0]  ready;
    logic [1:0]  req;
    logic [1:0]  valid;
    logic [1:0]  sol;
    logic [1:0]  eol;
    logic [1:0]  sof;
    logic [1:0]  uf;
    logic [23:0] data [2];
    logic [255:0] word [2];

    int n_chk = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [255:0] mk_word(input int n);
        logic [255:0] w;
        for (int j = 0; j < 8; j++) begin
            w[j*32 +: 32] = {8'hA5 ^ 8'(j), 24'(n + j)};
        end
        return w;
    endfunction

    for (genvar g = 0; g < 2; g++) begin : g_ch
        localparam int unsigned L = (g == 0) ? 6 : 12;

        logic [255:0] dly_w [L];
        logic [L-1:0] dly_v = '0;
        int gen_n = 0;
        int gen_base = 0;
        int n_pix = 0;
        int gap = 0;
        logic seen = 1'b0;
        logic hold_pend = 1'b0;
        logic [23:0] hold_data = '0;
        logic [26:0] exp_q [$];

        pixel_word_unpacker #(
            .WORD_W     (256),
            .SLOT_W     (32),
            .RD_LATENCY (L),
            .H_ACTIVE   (HA),
            .V_ACTIVE   (VA)
        ) u_dut (
            .clk_i       (clk),
            .rst_n_i     (rst_n),
            .start_i     (start[g]),
            .word_i      (word[g]),
            .req_o       (req[g]),
            .pix_data_o  (data[g]),
            .pix_valid_o (valid[g]),
            .pix_ready_i (ready[g]),
            .sol_o       (sol[g]),
            .eol_o       (eol[g]),
            .sof_o       (sof[g]),
            .underflow_o (uf[g])
        );

        assign word[g] = dly_w[L-1];

        // FIFO model: fixed read latency, junk on idle cycles; expected pixels queued at request time.
        always @(posedge clk) begin
            int p;
            int h;
            int v;
            dly_v <= {dly_v[L-2:0], req[g]};
            dly_w[0] <= req[g] ? mk_word(gen_n) : {8{32'hDEADBEEF}};
            for (int i = 1; i < L; i++) dly_w[i] <= dly_w[i-1];
            if (!rst_n) begin
                exp_q.delete();
                gen_base = gen_n;
            end else if (req[g]) begin
                chk($sformatf("outstanding%0d", g), 32'(|dly_v), 0);
                for (int j = 0; j < 8; j++) begin
                    p = gen_n + j - gen_base;
                    h = p % HA;
                    v = (p / HA) % VA;
                    exp_q.push_back({24'(gen_n + j), 1'(h == 0), 1'(h == HA - 1), 1'(h == 0 && v == 0)});
                end
                gen_n += 8;
            end
        end

        // Output monitor and scoreboard.
        always @(negedge clk) begin
            logic [26:0] e;
            if (!rst_n) begin
                seen = 1'b0;
                hold_pend = 1'b0;
            end else begin
                if (!valid[g]) chk($sformatf("idle_zero%0d", g), {data[g], sol[g], eol[g], sof[g]}, 0);
                if (hold_pend) begin
                    chk($sformatf("hold_v%0d", g), 32'(valid[g]), 1);
                    chk($sformatf("hold_d%0d", g), data[g], hold_data);
                end
                if (valid[g] && ready[g]) begin
                    chk($sformatf("sb_nonempty%0d", g), 32'(exp_q.size() > 0), 1);
                    if (exp_q.size() > 0) begin
                        e = exp_q.pop_front();
                        chk($sformatf("pix%0d", g), {data[g], sol[g], eol[g], sof[g]}, e);
                    end
                    n_pix++;
                end
                if (seen && !valid[g] && ready[g]) gap++;
                if (valid[g]) seen = 1'b1;
                hold_pend = valid[g] && !ready[g];
                hold_data = data[g];
            end
        end
    end

    initial begin
        int t;
        int gap0;
        int np0;
        rst_n = 1'b0;
        start = '0;
        ready = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        for (int g = 0; g < 2; g++) begin
            chk("rst_req", 32'(req[g]), 0);
            chk("rst_out", {valid[g], data[g], sol[g], eol[g], sof[g], uf[g]}, 0);
        end
        @(posedge clk); #1 rst_n = 1'b1;

        // First frame start, sustained ready.
        @(posedge clk); #1 start[0] = 1'b1; ready[0] = 1'b1;
        @(posedge clk);
        @(negedge clk);
        chk("fill_req", 32'(req[0]), 1);
        t = 0;
        while (!valid[0] && t < 40) begin @(negedge clk); t++; end
        chk("first_v", 32'(valid[0]), 1);
        chk("first_px", data[0], 0);
        chk("first_sof", 32'(sof[0]), 1);
        gap0 = g_ch[0].gap;
        t = 0;
        while (g_ch[0].n_pix < 64 && t < 200) begin @(negedge clk); t++; end
        chk("sus_cnt", 32'(g_ch[0].n_pix >= 64), 1);
        chk("sus_gap", g_ch[0].gap - gap0, 0);
        chk("sus_uf", 32'(uf[0]), 0);

        // Random backpressure.
        np0 = g_ch[0].n_pix;
        repeat (300) begin @(posedge clk); #1 ready[0] = 1'($urandom_range(0, 1)); end
        @(posedge clk); #1 ready[0] = 1'b1;
        chk("rnd_prog", 32'(g_ch[0].n_pix - np0 > 100), 1);
        chk("rnd_uf", 32'(uf[0]), 0);

        // Reset while the pixel at slot 3 is shown and a word is in flight.
        t = 0;
        while (!(valid[0] && data[0][2:0] == 3'd3) && t < 100) begin @(posedge clk); #1; t++; end
        chk("rst_slot3", 32'(data[0][2:0]), 3);
        chk("rst_inflight", 32'(|g_ch[0].dly_v), 1);
        rst_n = 1'b0; start[0] = 1'b0; ready[0] = 1'b0;
        @(posedge clk);
        @(negedge clk);
        chk("mid_rst_out", {req[0], valid[0], data[0], sol[0], eol[0], sof[0], uf[0]}, 0);
        @(posedge clk); #1 rst_n = 1'b1;
        repeat (10) begin
            @(negedge clk);
            chk("post_rst_idle", {req[0], valid[0]}, 0);
        end
        @(posedge clk); #1 start[0] = 1'b1; ready[0] = 1'b1;
        t = 0;
        while (!valid[0] && t < 40) begin @(negedge clk); t++; end
        chk("re_v", 32'(valid[0]), 1);
        chk("re_sof", 32'(sof[0]), 1);
        chk("re_px", data[0], 24'(g_ch[0].gen_base));
        repeat (40) @(posedge clk);

        // Slow FIFO channel: gaps, sticky underflow, order kept.
        #1 start[1] = 1'b1; ready[1] = 1'b1;
        repeat (200) @(posedge clk);
        @(negedge clk);
        chk("slow_gap", 32'(g_ch[1].gap > 0), 1);
        chk("slow_cnt", 32'(g_ch[1].n_pix > 40), 1);
        chk("slow_uf", 32'(uf[1]), 1);
        @(posedge clk); #1 ready[1] = 1'b0;
        repeat (10) @(posedge clk);
        @(negedge clk);
        chk("slow_uf_sticky", 32'(uf[1]), 1);
        chk("a_uf_final", 32'(uf[0]), 0);

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

endmodule
